icache_fill: RTL and testbench

- Instruction-cache refill engine, directly downstream of fetch1 and upstream of the icache CAM write port.
- On a CAM miss, fetch1 hands over a physical word address. The block then:
  - issues one line-sized burst read on the instruction memory bus;
  - writes each returned word, with its tag and flags, into the CAM;
  - signals completion or a bus fault back to fetch1.
- Replaces the ad-hoc single-word refill path in fetch1.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_fill.sv | 151 +++++++++++++++
 tb/tb_icache_fill.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared icache definitions: CAM flag encodings, physical address width,
// refill FSM state type and the CAM write payload.
package icache_pkg;

  localparam int unsigned PA_MSB = 28;
  localparam int unsigned PA_W   = PA_MSB - 1;

  localparam logic [1:0] IC_FLAG_VALID = 2'b01;
  localparam logic [1:0] IC_FLAG_FAULT = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} icf_state_t;

  typedef struct packed {
    logic [11:2]     index;
    logic [PA_MSB:12] tag;
    logic [31:0]     data;
    logic [1:0]      flags;
  } icf_cam_wr_t;

endpackage

// File: rtl/icache_fill.sv
// Instruction-cache refill engine: one line burst per miss, each beat written to the CAM.
// Optional critical-word-first ordering selected by ICACHE_FILL_CWF_EN.
module icache_fill
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic              clk_core,
  input  logic              reset_n,
  input  logic              fe1_fill_req,
  input  logic [PA_MSB:2]   fe1_fill_paddr,
  output logic              icf_fill_busy,
  output logic              icf_fill_done,
  output logic              icf_fill_err,
  output logic              icf_bus_req,
  output logic [PA_MSB:2]   icf_bus_addr,
  input  logic              bus_icf_ack,
  input  logic              bus_icf_rvalid,
  input  logic [31:0]       bus_icf_rdata,
  input  logic              bus_icf_err,
  output logic [11:2]       icf_cam_write_index,
  output logic              icf_cam_write_req_data,
  output logic [31:0]       icf_cam_write_data,
  output logic              icf_cam_write_req_tag_flags,
  output logic [PA_MSB:12]  icf_cam_write_tag,
  output logic [1:0]        icf_cam_write_flags
);

  localparam int unsigned LW_BITS = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W   = LW_BITS + 1;
  localparam logic [PA_MSB:2] OFF_MASK = PA_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  icf_state_t        state_q, state_d;
  logic [PA_MSB:2]   paddr_q, paddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bus_req_q, bus_req_d;
  logic [PA_MSB:2]   bus_addr_q, bus_addr_d;
  icf_cam_wr_t       cam_q, cam_d;
  logic              cam_we_q, cam_we_d;

  logic [PA_MSB:2]   line_start_c;
  logic [11:2]       start_off_c;
  logic [11:2]       beat_off_c;
  logic [11:2]       beat_index_c;

  // Burst start address and first-beat offset within the line
`ifdef ICACHE_FILL_CWF_EN
  assign line_start_c = fe1_fill_paddr;
  assign start_off_c  = paddr_q[11:2] & OFF_MASK[11:2];
`else
  assign line_start_c = fe1_fill_paddr & ~OFF_MASK;
  assign start_off_c  = '0;
`endif

  assign beat_off_c   = (start_off_c + 10'(cnt_q)) & OFF_MASK[11:2];
  assign beat_index_c = (paddr_q[11:2] & ~OFF_MASK[11:2]) | beat_off_c;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    cnt_d      = cnt_q;
    bus_addr_d = bus_addr_q;
    cam_d      = cam_q;
    cam_we_d   = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fe1_fill_req) begin
          state_d    = REQ;
          paddr_d    = fe1_fill_paddr;
          cnt_d      = '0;
          bus_addr_d = line_start_c;
        end
      end
      REQ: begin
        if (bus_icf_ack) state_d = DATA;
      end
      DATA: begin
        if (bus_icf_rvalid) begin
          cam_we_d    = 1'b1;
          cam_d.index = beat_index_c;
          cam_d.tag   = paddr_q[PA_MSB:12];
          cam_d.data  = bus_icf_rdata;
          cam_d.flags = bus_icf_err ? (IC_FLAG_VALID | IC_FLAG_FAULT) : IC_FLAG_VALID;
          cnt_d       = cnt_q + CNT_W'(1);
          // An error beat ends the burst early; its write still lands with the done pulse
          if (bus_icf_err || (cnt_q == LAST_BEAT)) begin
            state_d = DONE;
            err_d   = bus_icf_err;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    bus_req_d = (state_d == REQ);
  end

  // State and output registers
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      cam_q      <= '0;
      cam_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      cam_q      <= cam_d;
      cam_we_q   <= cam_we_d;
    end
  end

  assign icf_fill_busy               = busy_q;
  assign icf_fill_done               = done_q;
  assign icf_fill_err                = err_q;
  assign icf_bus_req                 = bus_req_q;
  assign icf_bus_addr                = bus_addr_q;
  assign icf_cam_write_index         = cam_q.index;
  assign icf_cam_write_req_data      = cam_we_q;
  assign icf_cam_write_data          = cam_q.data;
  assign icf_cam_write_req_tag_flags = cam_we_q;
  assign icf_cam_write_tag           = cam_q.tag;
  assign icf_cam_write_flags         = cam_q.flags;

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: table of directed fills, random fills, and a mid-burst reset.
// Expected beat order follows ICACHE_FILL_CWF_EN when it is defined.
module tb_icache_fill;

  localparam int unsigned LW = 8;

  logic        clk_core = 1'b0;
  logic        reset_n = 1'b0;
  logic        fe1_fill_req = 1'b0;
  logic [26:0] fe1_fill_paddr = '0;
  logic        icf_fill_busy, icf_fill_done, icf_fill_err, icf_bus_req;
  logic [26:0] icf_bus_addr;
  logic        bus_icf_ack = 1'b0;
  logic        bus_icf_rvalid = 1'b0;
  logic [31:0] bus_icf_rdata = '0;
  logic        bus_icf_err = 1'b0;
  logic [9:0]  icf_cam_write_index;
  logic        icf_cam_write_req_data, icf_cam_write_req_tag_flags;
  logic [31:0] icf_cam_write_data;
  logic [16:0] icf_cam_write_tag;
  logic [1:0]  icf_cam_write_flags;

  icache_fill #(.LINE_WORDS(LW)) dut (
    .clk_core                    (clk_core),
    .reset_n                     (reset_n),
    .fe1_fill_req                (fe1_fill_req),
    .fe1_fill_paddr              (fe1_fill_paddr),
    .icf_fill_busy               (icf_fill_busy),
    .icf_fill_done               (icf_fill_done),
    .icf_fill_err                (icf_fill_err),
    .icf_bus_req                 (icf_bus_req),
    .icf_bus_addr                (icf_bus_addr),
    .bus_icf_ack                 (bus_icf_ack),
    .bus_icf_rvalid              (bus_icf_rvalid),
    .bus_icf_rdata               (bus_icf_rdata),
    .bus_icf_err                 (bus_icf_err),
    .icf_cam_write_index         (icf_cam_write_index),
    .icf_cam_write_req_data      (icf_cam_write_req_data),
    .icf_cam_write_data          (icf_cam_write_data),
    .icf_cam_write_req_tag_flags (icf_cam_write_req_tag_flags),
    .icf_cam_write_tag           (icf_cam_write_tag),
    .icf_cam_write_flags         (icf_cam_write_flags)
  );

  always #5 clk_core = ~clk_core;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [9:0]  index;
    logic [31:0] data;
    logic [16:0] tag;
    logic [1:0]  flags;
  } wr_t;

  typedef struct {
    logic [26:0] paddr;
    int          ack_dly;
    int          err_beat;     // -1: no error beat
    logic [31:0] gap_pat;      // nibble k = idle cycles before beat k
    bit          poke_req;     // pulse fe1_fill_req during DATA
    logic [26:0] exp_bus_addr;
    logic [16:0] exp_tag;
  } vec_t;

  wr_t  wr_q[$];
  int   done_cyc[$];
  logic done_err[$];
  int   req_rises = 0;

  task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, want %0h", nm, what, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{icf_fill_busy, icf_fill_done, icf_fill_err, icf_bus_req, icf_bus_addr,
             icf_cam_write_index, icf_cam_write_req_data, icf_cam_write_data,
             icf_cam_write_req_tag_flags, icf_cam_write_tag, icf_cam_write_flags};
  endfunction

  // Reference model: line-relative addressing from plain arithmetic
  function automatic logic [26:0] ref_bus_addr(input logic [26:0] p);
`ifdef ICACHE_FILL_CWF_EN
    return p;
`else
    return p - 27'(p % LW);
`endif
  endfunction

  function automatic logic [9:0] ref_index(input logic [26:0] p, input int k);
    int unsigned lo, start;
    lo = p % 1024;
`ifdef ICACHE_FILL_CWF_EN
    start = lo % LW;
`else
    start = 0;
`endif
    return 10'((lo - lo % LW) + (start + k) % LW);
  endfunction

  function automatic logic [16:0] ref_tag(input logic [26:0] p);
    return 17'(p / 1024);
  endfunction

  // Monitor: records CAM writes, done pulses and bus request rises after each edge
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(posedge clk_core);
      #1;
      cyc++;
      if (icf_cam_write_req_data || icf_cam_write_req_tag_flags) begin
        chk("mon", "strobes_paired", icf_cam_write_req_tag_flags, icf_cam_write_req_data);
        wr_q.push_back('{cyc, icf_cam_write_index, icf_cam_write_data, icf_cam_write_tag, icf_cam_write_flags});
      end
      if (icf_fill_done) begin
        done_cyc.push_back(cyc);
        done_err.push_back(icf_fill_err);
        chk("mon", "busy_at_done", icf_fill_busy, 1'b1);
      end
      if (icf_bus_req && !prev_req) req_rises++;
      prev_req = icf_bus_req;
    end
  end

  task automatic run_fill(input vec_t v, input string nm);
    wr_t exp_q[$];
    int  n, last_cyc, rises0, bound;
    logic [31:0] d;
    wr_q.delete(); done_cyc.delete(); done_err.delete();
    rises0 = req_rises;
    last_cyc = 0;

    @(negedge clk_core);
    fe1_fill_req = 1'b1;
    fe1_fill_paddr = v.paddr;
    @(negedge clk_core);
    fe1_fill_req = 1'b0;
    fe1_fill_paddr = 27'($urandom);
    chk(nm, "busy_rise", icf_fill_busy, 1'b1);
    chk(nm, "bus_req", icf_bus_req, 1'b1);
    chk(nm, "bus_addr", icf_bus_addr, v.exp_bus_addr);

    repeat (v.ack_dly) @(negedge clk_core);
    chk(nm, "bus_addr_at_ack", icf_bus_addr, v.exp_bus_addr);
    bus_icf_ack = 1'b1;
    @(negedge clk_core);
    bus_icf_ack = 1'b0;
    chk(nm, "bus_req_drop", icf_bus_req, 1'b0);

    n = (v.err_beat >= 0) ? v.err_beat + 1 : LW;
    for (int k = 0; k < n; k++) begin
      repeat (int'(v.gap_pat[4*k +: 4])) @(negedge clk_core);
      d = $urandom;
      bus_icf_rvalid = 1'b1;
      bus_icf_rdata = d;
      bus_icf_err = (k == v.err_beat);
      if (v.poke_req && k == n / 2) begin
        fe1_fill_req = 1'b1;
        fe1_fill_paddr = 27'($urandom);
      end
      last_cyc = cyc + 1;
      exp_q.push_back('{last_cyc, ref_index(v.paddr, k), d, v.exp_tag,
                        (k == v.err_beat) ? 2'b11 : 2'b01});
      @(negedge clk_core);
      bus_icf_rvalid = 1'b0;
      bus_icf_err = 1'b0;
      bus_icf_rdata = $urandom;
      fe1_fill_req = 1'b0;
    end

    bound = 0;
    while (done_cyc.size() == 0 && bound < 20) begin
      @(negedge clk_core);
      bound++;
    end
    chk(nm, "done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk(nm, "done_cyc", done_cyc[0], last_cyc);
      chk(nm, "done_err", done_err[0], (v.err_beat >= 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk_core);
    chk(nm, "busy_drop", icf_fill_busy, 1'b0);
    repeat (3) @(negedge clk_core);

    chk(nm, "nwrites", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk(nm, "wr_cyc", wr_q[i].cyc, exp_q[i].cyc);
      chk(nm, "wr_index", wr_q[i].index, exp_q[i].index);
      chk(nm, "wr_data", wr_q[i].data, exp_q[i].data);
      chk(nm, "wr_tag_flags", {wr_q[i].tag, wr_q[i].flags}, {exp_q[i].tag, exp_q[i].flags});
    end
    chk(nm, "bus_req_count", req_rises - rises0, 1);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;

    tbl[0] = '{27'h0012345, 2, -1, 32'h0, 1'b0, 27'h0, 17'h00048};
`ifdef ICACHE_FILL_CWF_EN
    tbl[0].exp_bus_addr = 27'h0012345;
`else
    tbl[0].exp_bus_addr = 27'h0012340;
`endif
    tbl[1] = '{27'h2a0bc18, 0, -1, 32'h0000_4020, 1'b0, 27'h0, 17'h0};
    tbl[2] = '{27'h0777770, 1, 3, 32'h0, 1'b0, 27'h0, 17'h0};
    tbl[3] = '{27'h1000000, 0, -1, 32'h0101_0101, 1'b1, 27'h0, 17'h0};
    tbl[4] = '{27'h0012346, 3, -1, 32'h0, 1'b0, 27'h0, 17'h00048};
`ifdef ICACHE_FILL_CWF_EN
    tbl[4].exp_bus_addr = 27'h0012346;
`else
    tbl[4].exp_bus_addr = 27'h0012340;
`endif
    tbl[5] = '{27'h7ffffff, 0, 0, 32'h0, 1'b0, 27'h0, 17'h0};
    for (int i = 1; i < 6; i++) begin
      if (i != 4) begin
        tbl[i].exp_bus_addr = ref_bus_addr(tbl[i].paddr);
        tbl[i].exp_tag = ref_tag(tbl[i].paddr);
      end
    end

    repeat (2) @(negedge clk_core);
    chk("reset", "outputs_zero", any_out(), 1'b0);
    reset_n = 1'b1;
    @(negedge clk_core);
    chk("reset", "idle_outputs_zero", any_out(), 1'b0);

    for (int i = 0; i < 6; i++) run_fill(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v.paddr = 27'($urandom);
      v.ack_dly = int'($urandom_range(0, 3));
      v.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      v.gap_pat = $urandom & 32'h3333_3333;
      v.poke_req = 1'($urandom);
      v.exp_bus_addr = ref_bus_addr(v.paddr);
      v.exp_tag = ref_tag(v.paddr);
      run_fill(v, $sformatf("rnd%0d", i));
    end

    // Reset for one cycle after four beats: fill abandoned, no done pulse
    wr_q.delete(); done_cyc.delete();
    @(negedge clk_core);
    fe1_fill_req = 1'b1;
    fe1_fill_paddr = 27'h0055550;
    @(negedge clk_core);
    fe1_fill_req = 1'b0;
    bus_icf_ack = 1'b1;
    @(negedge clk_core);
    bus_icf_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_icf_rvalid = 1'b1;
      bus_icf_rdata = $urandom;
      @(negedge clk_core);
    end
    bus_icf_rvalid = 1'b0;
    chk("midrst", "writes_before", wr_q.size(), 4);
    chk("midrst", "busy_before", icf_fill_busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk_core);
    reset_n = 1'b1;
    chk("midrst", "outputs_zero", any_out(), 1'b0);
    repeat (6) @(negedge clk_core);
    chk("midrst", "no_done", done_cyc.size(), 0);
    chk("midrst", "no_more_writes", wr_q.size(), 4);
    chk("midrst", "idle_busy", icf_fill_busy, 1'b0);
    run_fill(tbl[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
